dd_input_ctrl: RTL and testbench
================================

# dd_input_ctrl

Player-input conditioning stage feeding the DigDug core's `INP0`/`INP1` buses. It:
- decodes the HPS PS/2 key stream into held-key state and merges it with both joysticks;
- shapes each coin press into a fixed-length, frame-counted pulse the game CPU cannot miss;
- registers the two input bytes.

It replaces the ad-hoc key latches and combinational merge in the top level and sits directly upstream of the game core.

## Interface
Parameters:
- `COIN_FRAMES`, 4, coin pulse length in vblank rising edges; legal range 1..15.

Ports:
- `clk_sys`  in  1  system clock (HPS domain); one clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `ps2_key`  in  11  [10] toggle per event, [9] pressed, [8] extended, [7:0] scan code.
- `joystk1`, `joystk2`  in  16  active-high: [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2 [7]coin.
- `vblank`  in  1  vertical blank from the video timing generator, pixel-clock domain, asynchronous to `clk_sys`.
- `service`  in  1  OSD service-mode switch, static.
- `cabinet`  in  1  0 upright, 1 cocktail; present only with `DD_COCKTAIL_EN`.
- `inp0`  out  8  {service, 0, coin2, coin1, start2, start1, trig2, trig1}.
- `inp1`  out  8  {left2, down2, right2, up2, left1, down1, right1, up1}.
- `coin_busy`  out  2  per-coin shaper not in IDLE (bit0 coin1), for LED/debug.

## Operation
- **Key decoder:**
  - Register `ps2_key[10]`; an event occurs when it differs from the registered copy.
  - On an event, match `{ps2_key[8], ps2_key[7:0]}` and write `ps2_key[9]` into that key's latch. Unmatched codes are ignored.
  - Arrow codes 0x75/0x72/0x6B/0x74 match with either value of bit 8 → up1/down1/left1/right1.
  - Other keys match only with bit 8 = 0:
    - 0x29 space and 0x14 ctrl share a single latch, fire1 (last event wins).
    - 0x05 F1 → start1 and coin1; 0x06 F2 → start2 and coin2.
    - 0x16 → start1; 0x1E → start2; 0x2E → coin1; 0x36 → coin2.
    - 0x2D/0x2B/0x23/0x34 → up2/down2/left2/right2.
    - 0x1C and 0x1B share a single latch, fire2 (last event wins).
- **Merge:**
  - Player-2 bits are the key latch OR `joystk2`.
  - Player-1 bits are the key latch OR `joystk1` OR the player-2 bits (upright cabinet).
  - start1/start2 are the OR of the keys and both joysticks' [5]/[6].
  - The raw coins are coin1 = keys | `joystk1[7]` and coin2 = keys | `joystk2[7]`; these feed the shapers.
- **Vblank sync:** two-flop synchronizer, then a rising-edge detect giving a one-cycle `vb_rise`.
- **Coin shaper:** one per coin, with states IDLE, PULSE, HOLD.
  - IDLE → PULSE on a raw-coin rising edge (raw coin registered, then edge-detected); load `cnt = COIN_FRAMES`.
  - PULSE: coin output is 1. Decrement `cnt` on each `vb_rise`; when `cnt` reaches 0, go to HOLD. A raw release during PULSE does not shorten the pulse.
  - HOLD: coin output is 0. Go to IDLE on the first cycle the raw coin is 0; no re-trigger while the coin is held.
  - `vb_rise` in the same cycle as PULSE entry is not counted.
- **Outputs:** `inp0`/`inp1` are registered every cycle from the merged and shaped bits; `inp0[6]` is constant 0.

## Timing
- Reset: every key latch, shaper state (IDLE), counter, synchronizer flop, `inp0`, `inp1` and `coin_busy` is 0. An asynchronous reset mid-pulse aborts the pulse immediately.
- Key event in cycle N: latch updates at N+1, `inp*` at N+2.
- Joystick or service change: `inp*` changes 1 cycle later.
- Coin raw rise in cycle N: edge register at N+1, shaper enters PULSE at N+2, `inp0` coin bit high at N+3.
- Pulse length: exactly `COIN_FRAMES` `vb_rise` events.
- `vblank` edge to `vb_rise`: 2–3 `clk_sys` cycles.
- Simultaneous coin1 and coin2 are independent; keyboard and joystick sources of the same bit are ORed, with no priority.

## Configuration
- `DD_COCKTAIL_EN` defined:
  - the `cabinet` port exists;
  - when `cabinet` = 1, the player-2 bits are not ORed into player 1;
  - when `cabinet` = 0, behaviour is the upright behaviour.
- `DD_COCKTAIL_EN` undefined: no `cabinet` port; upright OR behaviour is hard-wired.

## Structure
- Package `dd_input_pkg` holds:
  - the scan-code localparams;
  - the `inp0`/`inp1` bit-index constants;
  - the joystick bit-index constants;
  - the enum `coin_state_t` {IDLE, PULSE, HOLD}.
- Sub-module `dd_coin_pulse`: one shaper, parameterised by `COIN_FRAMES`, instantiated twice. The decoder, synchronizer and merge stay in the top.

## Test plan
- Reset release with all inputs 0 → `inp0` = 0x00, `inp1` = 0x00, `coin_busy` = 0.
- Toggle `ps2_key` with {pressed=1, ext=1, 0x75}, then {pressed=0, ext=1, 0x75} → `inp1[0]` = 1 two cycles after the first event, 0 two cycles after the second; `inp1[4]` stays 0.
- `joystk2[1]` = 1, upright → `inp1` = 0x88 one cycle later. Under `DD_COCKTAIL_EN` with `cabinet` = 1 → `inp1` = 0x80.
- `joystk1[7]` held 1 across 10 vblanks, `COIN_FRAMES` = 4 → `inp0[4]` high for exactly 4 `vb_rise` events then low. No second pulse until the coin is released and pressed again.
- Coin tap of 1 cycle, then assert `rst_n` = 0 after 2 vblanks → `inp0[4]` drops asynchronously; after release the shaper is IDLE and no pulse occurs.
- Keyboard 0x2E and `joystk2[7]` rising in the same cycle → `inp0[4]` and `inp0[5]` both high at N+3, with equal pulse lengths.

Source files
------------

// File: rtl/dd_input_pkg.sv
// Shared constants for the DigDug player-input stage: PS/2 scan codes,
// INP0/INP1 and joystick bit positions, and the coin shaper states.
package dd_input_pkg;

  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_F1     = 8'h05;
  localparam logic [7:0] SC_F2     = 8'h06;
  localparam logic [7:0] SC_1      = 8'h16;
  localparam logic [7:0] SC_2      = 8'h1E;
  localparam logic [7:0] SC_5      = 8'h2E;
  localparam logic [7:0] SC_6      = 8'h36;
  localparam logic [7:0] SC_R      = 8'h2D;
  localparam logic [7:0] SC_F      = 8'h2B;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_G      = 8'h34;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_S      = 8'h1B;

  localparam int INP0_TRIG1   = 0;
  localparam int INP0_TRIG2   = 1;
  localparam int INP0_START1  = 2;
  localparam int INP0_START2  = 3;
  localparam int INP0_COIN1   = 4;
  localparam int INP0_COIN2   = 5;
  localparam int INP0_SERVICE = 7;

  localparam int INP1_UP1     = 0;
  localparam int INP1_RIGHT1  = 1;
  localparam int INP1_DOWN1   = 2;
  localparam int INP1_LEFT1   = 3;
  localparam int INP1_UP2     = 4;
  localparam int INP1_RIGHT2  = 5;
  localparam int INP1_DOWN2   = 6;
  localparam int INP1_LEFT2   = 7;

  localparam int JOY_RIGHT    = 0;
  localparam int JOY_LEFT     = 1;
  localparam int JOY_DOWN     = 2;
  localparam int JOY_UP       = 3;
  localparam int JOY_FIRE     = 4;
  localparam int JOY_START1   = 5;
  localparam int JOY_START2   = 6;
  localparam int JOY_COIN     = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } coin_state_t;

endpackage

// File: rtl/dd_coin_pulse.sv
// One coin shaper: turns a raw coin press into a pulse lasting exactly
// COIN_FRAMES vblank rising edges, then waits for the coin to be released.
//
//   state | meaning
//   IDLE  | armed, waiting for a raw coin rising edge
//   PULSE | coin output high, counting vb_rise down to zero
//   HOLD  | pulse done, waiting for the raw coin to drop
module dd_coin_pulse
  import dd_input_pkg::*;
#(
  parameter int COIN_FRAMES = 4
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic raw,
  input  logic vb_rise,
  output logic pulse,
  output logic busy
);

  localparam logic [3:0] CNT_LOAD = 4'(COIN_FRAMES);

  coin_state_t state;
  logic        raw_q;
  logic        rise_q;
  logic [3:0]  cnt;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      raw_q  <= 1'b0;
      rise_q <= 1'b0;
      cnt    <= 4'd0;
    end else begin
      raw_q  <= raw;
      rise_q <= raw & ~raw_q;
      case (state)
        IDLE: begin
          if (rise_q) begin
            state <= PULSE;
            cnt   <= CNT_LOAD;
          end
        end
        PULSE: begin
          // the raw level is ignored here so a short tap still gets a full pulse
          if (vb_rise) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= HOLD;
          end
        end
        HOLD: begin
          if (!raw) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pulse = (state == PULSE);
  assign busy  = (state != IDLE);

endmodule

// File: rtl/dd_input_ctrl.sv
// DigDug input conditioning: PS/2 key latches merged with both joysticks,
// frame-counted coin pulses, registered INP0/INP1. Option: DD_COCKTAIL_EN.
module dd_input_ctrl
  import dd_input_pkg::*;
#(
  parameter int COIN_FRAMES = 4
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystk1,
  input  logic [15:0] joystk2,
  input  logic        vblank,
  input  logic        service,
`ifdef DD_COCKTAIL_EN
  input  logic        cabinet,
`endif
  output logic [7:0]  inp0,
  output logic [7:0]  inp1,
  output logic [1:0]  coin_busy
);

  logic tgl_q;
  logic key_evt;
  logic k_up1, k_down1, k_left1, k_right1, k_fire1;
  logic k_up2, k_down2, k_left2, k_right2, k_fire2;
  logic k_start1, k_start2, k_coin1, k_coin2;

  assign key_evt = ps2_key[10] ^ tgl_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      tgl_q    <= 1'b0;
      k_up1    <= 1'b0;
      k_down1  <= 1'b0;
      k_left1  <= 1'b0;
      k_right1 <= 1'b0;
      k_fire1  <= 1'b0;
      k_up2    <= 1'b0;
      k_down2  <= 1'b0;
      k_left2  <= 1'b0;
      k_right2 <= 1'b0;
      k_fire2  <= 1'b0;
      k_start1 <= 1'b0;
      k_start2 <= 1'b0;
      k_coin1  <= 1'b0;
      k_coin2  <= 1'b0;
    end else begin
      tgl_q <= ps2_key[10];
      if (key_evt) begin
        // arrows arrive with or without the E0 prefix depending on the keyboard
        case (ps2_key[7:0])
          SC_UP:    k_up1    <= ps2_key[9];
          SC_DOWN:  k_down1  <= ps2_key[9];
          SC_LEFT:  k_left1  <= ps2_key[9];
          SC_RIGHT: k_right1 <= ps2_key[9];
          default: ;
        endcase
        if (!ps2_key[8]) begin
          case (ps2_key[7:0])
            SC_SPACE, SC_CTRL: k_fire1 <= ps2_key[9];
            SC_F1: begin
              k_start1 <= ps2_key[9];
              k_coin1  <= ps2_key[9];
            end
            SC_F2: begin
              k_start2 <= ps2_key[9];
              k_coin2  <= ps2_key[9];
            end
            SC_1:     k_start1 <= ps2_key[9];
            SC_2:     k_start2 <= ps2_key[9];
            SC_5:     k_coin1  <= ps2_key[9];
            SC_6:     k_coin2  <= ps2_key[9];
            SC_R:     k_up2    <= ps2_key[9];
            SC_F:     k_down2  <= ps2_key[9];
            SC_D:     k_left2  <= ps2_key[9];
            SC_G:     k_right2 <= ps2_key[9];
            SC_A, SC_S: k_fire2 <= ps2_key[9];
            default: ;
          endcase
        end
      end
    end
  end

  logic vb_meta, vb_sync, vb_prev;
  logic vb_rise;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      vb_meta <= 1'b0;
      vb_sync <= 1'b0;
      vb_prev <= 1'b0;
    end else begin
      vb_meta <= vblank;
      vb_sync <= vb_meta;
      vb_prev <= vb_sync;
    end
  end

  assign vb_rise = vb_sync & ~vb_prev;

  // upright cabinets let either player's controls drive player 1
  logic p2_to_p1;
`ifdef DD_COCKTAIL_EN
  assign p2_to_p1 = ~cabinet;
`else
  assign p2_to_p1 = 1'b1;
`endif

  logic up1, down1, left1, right1, trig1;
  logic up2, down2, left2, right2, trig2;
  logic start1, start2, coin1_raw, coin2_raw;

  assign up2    = k_up2    | joystk2[JOY_UP];
  assign down2  = k_down2  | joystk2[JOY_DOWN];
  assign left2  = k_left2  | joystk2[JOY_LEFT];
  assign right2 = k_right2 | joystk2[JOY_RIGHT];
  assign trig2  = k_fire2  | joystk2[JOY_FIRE];

  assign up1    = k_up1    | joystk1[JOY_UP]    | (up2    & p2_to_p1);
  assign down1  = k_down1  | joystk1[JOY_DOWN]  | (down2  & p2_to_p1);
  assign left1  = k_left1  | joystk1[JOY_LEFT]  | (left2  & p2_to_p1);
  assign right1 = k_right1 | joystk1[JOY_RIGHT] | (right2 & p2_to_p1);
  assign trig1  = k_fire1  | joystk1[JOY_FIRE]  | (trig2  & p2_to_p1);

  assign start1    = k_start1 | joystk1[JOY_START1] | joystk2[JOY_START1];
  assign start2    = k_start2 | joystk1[JOY_START2] | joystk2[JOY_START2];
  assign coin1_raw = k_coin1  | joystk1[JOY_COIN];
  assign coin2_raw = k_coin2  | joystk2[JOY_COIN];

  logic unused_joy_hi;
  assign unused_joy_hi = ^{joystk1[15:8], joystk2[15:8]};

  logic coin1_pulse, coin2_pulse;
  logic coin1_busy, coin2_busy;

  dd_coin_pulse #(.COIN_FRAMES(COIN_FRAMES)) u_coin1 (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .raw     (coin1_raw),
    .vb_rise (vb_rise),
    .pulse   (coin1_pulse),
    .busy    (coin1_busy)
  );

  dd_coin_pulse #(.COIN_FRAMES(COIN_FRAMES)) u_coin2 (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .raw     (coin2_raw),
    .vb_rise (vb_rise),
    .pulse   (coin2_pulse),
    .busy    (coin2_busy)
  );

  assign coin_busy = {coin2_busy, coin1_busy};

  logic [7:0] inp0_d, inp1_d;

  always_comb begin
    inp0_d = 8'h00;
    inp0_d[INP0_TRIG1]   = trig1;
    inp0_d[INP0_TRIG2]   = trig2;
    inp0_d[INP0_START1]  = start1;
    inp0_d[INP0_START2]  = start2;
    inp0_d[INP0_COIN1]   = coin1_pulse;
    inp0_d[INP0_COIN2]   = coin2_pulse;
    inp0_d[INP0_SERVICE] = service;

    inp1_d = 8'h00;
    inp1_d[INP1_UP1]    = up1;
    inp1_d[INP1_RIGHT1] = right1;
    inp1_d[INP1_DOWN1]  = down1;
    inp1_d[INP1_LEFT1]  = left1;
    inp1_d[INP1_UP2]    = up2;
    inp1_d[INP1_RIGHT2] = right2;
    inp1_d[INP1_DOWN2]  = down2;
    inp1_d[INP1_LEFT2]  = left2;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      inp0 <= 8'h00;
      inp1 <= 8'h00;
    end else begin
      inp0 <= inp0_d;
      inp1 <= inp1_d;
    end
  end

endmodule

// File: tb/tb_dd_input_ctrl.sv
// Bench for dd_input_ctrl: segments of stimulus are generated up front, a
// timeline model predicts every output cycle, and a monitor checks them.
module tb_dd_input_ctrl;

  localparam int CF   = 4;
  localparam int MAXL = 320;

  localparam int B_UP1 = 0, B_DN1 = 1, B_LF1 = 2, B_RT1 = 3, B_F1 = 4;
  localparam int B_UP2 = 5, B_DN2 = 6, B_LF2 = 7, B_RT2 = 8, B_F2 = 9;
  localparam int B_S1 = 10, B_S2 = 11, B_C1 = 12, B_C2 = 13;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [10:0] ps2_key;
  logic [15:0] joystk1, joystk2;
  logic        vblank, service;
  logic        cab = 1'b0;
  logic [7:0]  inp0, inp1;
  logic [1:0]  coin_busy;

  dd_input_ctrl #(.COIN_FRAMES(CF)) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .ps2_key   (ps2_key),
    .joystk1   (joystk1),
    .joystk2   (joystk2),
    .vblank    (vblank),
    .service   (service),
`ifdef DD_COCKTAIL_EN
    .cabinet   (cab),
`endif
    .inp0      (inp0),
    .inp1      (inp1),
    .coin_busy (coin_busy)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] i0;
    logic [7:0] i1;
    logic [1:0] b;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit fin_req = 0;
  bit mon_done = 0;

  // stimulus vectors and model results for one segment
  logic [15:0] s_j1[MAXL], s_j2[MAXL];
  logic [10:0] s_key[MAXL];
  logic        s_vb[MAXL], s_svc[MAXL];
  logic [7:0]  m_pre0[MAXL], m_inp1[MAXL], e_inp0[MAXL], e_inp1[MAXL];
  logic [1:0]  e_busy[MAXL];
  logic        raw_a[2][MAXL];
  logic        vbr_a[MAXL];
  int          st_a[2][MAXL];

  logic [7:0] codes[20] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h06,
                            8'h16, 8'h1E, 8'h2E, 8'h36, 8'h2D, 8'h2B, 8'h23, 8'h34,
                            8'h1C, 8'h1B, 8'h11, 8'h55};

  function automatic logic [13:0] key_map(input logic ext, input logic [7:0] code);
    logic [13:0] m;
    m = '0;
    case (code)
      8'h75: m[B_UP1] = 1'b1;
      8'h72: m[B_DN1] = 1'b1;
      8'h6B: m[B_LF1] = 1'b1;
      8'h74: m[B_RT1] = 1'b1;
      default: if (!ext) begin
        case (code)
          8'h29, 8'h14: m[B_F1] = 1'b1;
          8'h05: begin m[B_S1] = 1'b1; m[B_C1] = 1'b1; end
          8'h06: begin m[B_S2] = 1'b1; m[B_C2] = 1'b1; end
          8'h16: m[B_S1] = 1'b1;
          8'h1E: m[B_S2] = 1'b1;
          8'h2E: m[B_C1] = 1'b1;
          8'h36: m[B_C2] = 1'b1;
          8'h2D: m[B_UP2] = 1'b1;
          8'h2B: m[B_DN2] = 1'b1;
          8'h23: m[B_LF2] = 1'b1;
          8'h34: m[B_RT2] = 1'b1;
          8'h1C, 8'h1B: m[B_F2] = 1'b1;
          default: ;
        endcase
      end
    endcase
    return m;
  endfunction

  task automatic clear_stim();
    for (int c = 0; c < MAXL; c++) begin
      s_j1[c] = '0; s_j2[c] = '0; s_key[c] = '0; s_vb[c] = 1'b0; s_svc[c] = 1'b0;
    end
  endtask

  task automatic put_key(input int c, input bit prs, input bit ext, input logic [7:0] code);
    logic t;
    t = (c == 0) ? 1'b0 : s_key[c-1][10];
    for (int k = c; k < MAXL; k++) s_key[k] = {~t, prs, ext, code};
  endtask

  task automatic set_vb(input int per, input int ph);
    for (int c = 0; c < MAXL; c++) s_vb[c] = (((c + ph) % per) >= (per / 2));
  endtask

  function automatic bit edge_at(input int w, input int t);
    if (t < 1) return 1'b0;
    return raw_a[w][t-1] && (t < 2 || !raw_a[w][t-2]);
  endfunction

  // Coin timeline: 0 idle, 1 pulsing, 2 waiting for release, found by scanning forward.
  task automatic coin_timeline(input int w, input int len);
    int pos, t, e, h, n;
    for (int c = 0; c < len; c++) st_a[w][c] = 0;
    pos = 0;
    while (pos < len) begin
      t = pos;
      while (t < len && !edge_at(w, t)) t++;
      if (t >= len - 1) break;
      e = t + 1;
      n = 0;
      while (e < len) begin
        st_a[w][e] = 1;
        if (vbr_a[e]) n++;
        if (n == CF) break;
        e++;
      end
      if (e >= len) break;
      h = e + 1;
      while (h < len) begin
        st_a[w][h] = 2;
        if (!raw_a[w][h]) break;
        h++;
      end
      pos = h + 1;
    end
  endtask

  task automatic model(input int len);
    logic [13:0] ks;
    logic        ptgl;
    logic [7:0]  j1, j2;
    logic [3:0]  p1, p2;
    logic        t1, t2, s1, s2;
    ks = '0;
    ptgl = 1'b0;
    for (int c = 0; c < len; c++) begin
      j1 = s_j1[c][7:0];
      j2 = s_j2[c][7:0];
      p2 = {ks[B_LF2] | j2[1], ks[B_DN2] | j2[2], ks[B_RT2] | j2[0], ks[B_UP2] | j2[3]};
      p1 = {ks[B_LF1] | j1[1], ks[B_DN1] | j1[2], ks[B_RT1] | j1[0], ks[B_UP1] | j1[3]};
      t2 = ks[B_F2] | j2[4];
      t1 = ks[B_F1] | j1[4];
      if (!cab) begin p1 = p1 | p2; t1 = t1 | t2; end
      s1 = ks[B_S1] | j1[5] | j2[5];
      s2 = ks[B_S2] | j1[6] | j2[6];
      m_inp1[c] = {p2, p1};
      m_pre0[c] = {s_svc[c], 3'b000, s2, s1, t2, t1};
      raw_a[0][c] = ks[B_C1] | j1[7];
      raw_a[1][c] = ks[B_C2] | j2[7];
      vbr_a[c] = (c >= 2) && s_vb[c-2] && !(c >= 3 && s_vb[c-3]);
      if (s_key[c][10] != ptgl) begin
        ptgl = s_key[c][10];
        if (s_key[c][9]) ks = ks | key_map(s_key[c][8], s_key[c][7:0]);
        else             ks = ks & ~key_map(s_key[c][8], s_key[c][7:0]);
      end
    end
    coin_timeline(0, len);
    coin_timeline(1, len);
    for (int c = 0; c < len; c++) begin
      e_busy[c] = {st_a[1][c] != 0, st_a[0][c] != 0};
      if (c == 0) begin
        e_inp0[c] = 8'h00;
        e_inp1[c] = 8'h00;
      end else begin
        e_inp0[c] = m_pre0[c-1] | {2'b00, st_a[1][c-1] == 1, st_a[0][c-1] == 1, 4'b0000};
        e_inp1[c] = m_inp1[c-1];
      end
    end
  endtask

  task automatic drive(input int c);
    joystk1 = s_j1[c];
    joystk2 = s_j2[c];
    ps2_key = s_key[c];
    vblank  = s_vb[c];
    service = s_svc[c];
  endtask

  task automatic run_seg(input int len, input bit rst_end);
    int base;
    model(len);
    @(posedge clk_sys); #1;
    rst_n = 1'b0;
    joystk1 = '0; joystk2 = '0; ps2_key = '0; vblank = 1'b0; service = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    base = cyc;
    for (int c = 0; c < len; c++) begin
      if (c > 0) begin @(posedge clk_sys); #1; end
      drive(c);
      if (c == 0) rst_n = 1'b1;
      exp_q.push_back('{base + c, e_inp0[c], e_inp1[c], e_busy[c]});
    end
    if (rst_end) begin
      @(posedge clk_sys); #1;
      rst_n = 1'b0;
      exp_q.push_back('{base + len, 8'h00, 8'h00, 2'b00});
    end
  endtask

  task automatic gen_random(input int len);
    logic [15:0] j1v, j2v;
    logic        sv;
    int          per;
    clear_stim();
`ifdef DD_COCKTAIL_EN
    cab = 1'($urandom_range(1, 0));
`endif
    per = $urandom_range(30, 8);
    set_vb(per, $urandom_range(per - 1, 0));
    j1v = '0; j2v = '0; sv = 1'b0;
    for (int c = 0; c < len; c++) begin
      if ($urandom_range(15, 0) == 0) j1v = 16'($urandom & $urandom & $urandom);
      if ($urandom_range(15, 0) == 0) j2v = 16'($urandom & $urandom & $urandom);
      if ($urandom_range(99, 0) == 0) sv = ~sv;
      s_j1[c] = j1v; s_j2[c] = j2v; s_svc[c] = sv;
    end
    for (int c = 0; c < len; c++)
      if ($urandom_range(7, 0) == 0)
        put_key(c, 1'($urandom_range(1, 0)), 1'($urandom_range(3, 0) == 0),
                codes[$urandom_range(19, 0)]);
  endtask

  always @(negedge clk_sys) begin
    exp_t ex;
    while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      ex = exp_q.pop_front();
      if (ex.cyc != cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL stale_expect cyc=%0d now=%0d", ex.cyc, cyc);
      end else begin
        n_cmp++;
        if (inp0 !== ex.i0) begin
          n_bad++;
          $display("FAIL inp0 cyc=%0d got=%02h exp=%02h", cyc, inp0, ex.i0);
        end
        n_cmp++;
        if (inp1 !== ex.i1) begin
          n_bad++;
          $display("FAIL inp1 cyc=%0d got=%02h exp=%02h", cyc, inp1, ex.i1);
        end
        n_cmp++;
        if (coin_busy !== ex.b) begin
          n_bad++;
          $display("FAIL coin_busy cyc=%0d got=%b exp=%b", cyc, coin_busy, ex.b);
        end
      end
    end
    if (fin_req && !mon_done) begin
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL leftover_expect got=%0d exp=0", exp_q.size());
      end
      mon_done = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    joystk1 = '0; joystk2 = '0; ps2_key = '0; vblank = 1'b0; service = 1'b0;

    // reset state with idle inputs
    clear_stim();
    run_seg(6, 1'b0);

    // extended up-arrow press and release
    clear_stim();
    put_key(3, 1'b1, 1'b1, 8'h75);
    put_key(10, 1'b0, 1'b1, 8'h75);
    put_key(14, 1'b1, 1'b0, 8'h29);
    put_key(18, 1'b0, 1'b0, 8'h14);
    run_seg(24, 1'b0);

    // player-2 left reaches player 1 on an upright cabinet
    clear_stim();
    for (int c = 2; c < 10; c++) s_j2[c] = 16'h0002;
    s_svc[6] = 1'b1;
    run_seg(14, 1'b0);
`ifdef DD_COCKTAIL_EN
    cab = 1'b1;
    run_seg(14, 1'b0);
    cab = 1'b0;
`endif

    // held coin: one pulse, no retrigger until released and pressed again
    clear_stim();
    set_vb(12, 0);
    for (int c = 3; c < 150; c++) s_j1[c] = 16'h0080;
    for (int c = 165; c < 225; c++) s_j1[c] = 16'h0080;
    run_seg(240, 1'b0);

    // one-cycle tap, reset mid-pulse, then nothing after release
    clear_stim();
    set_vb(20, 0);
    s_j1[2] = 16'h0080;
    run_seg(40, 1'b1);
    clear_stim();
    set_vb(20, 0);
    run_seg(100, 1'b0);

    // keyboard coin1 and joystick coin2 rising together
    clear_stim();
    set_vb(16, 5);
    put_key(4, 1'b1, 1'b0, 8'h2E);
    for (int c = 5; c < 100; c++) s_j2[c] = 16'h0080;
    put_key(99, 1'b0, 1'b0, 8'h2E);
    run_seg(150, 1'b0);

    // F1/F2 drive start and coin together
    clear_stim();
    set_vb(10, 0);
    put_key(2, 1'b1, 1'b0, 8'h05);
    put_key(3, 1'b1, 1'b0, 8'h06);
    put_key(70, 1'b0, 1'b0, 8'h05);
    put_key(72, 1'b0, 1'b0, 8'h06);
    run_seg(90, 1'b0);

    for (int s = 0; s < 6; s++) begin
      gen_random(300);
      run_seg(300, 1'($urandom_range(1, 0)));
    end

    repeat (3) @(posedge clk_sys);
    fin_req = 1'b1;
    for (int i = 0; i < 10 && !mon_done; i++) @(posedge clk_sys);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
